// File: rtl/alarm_scheduler_if.sv
// Client-side bundle of the shared alarm timer: level requests and delays in,
// grant / status / beep / done back out.
interface alarm_scheduler_if #(
  parameter int N  = 4,
  parameter int DW = 4
);
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  logic [N-1:0]    req;
  logic [N*DW-1:0] delay;
  logic [N-1:0]    grant;
  logic [IW-1:0]   active_id;
  logic            busy;
  logic            beep;
  logic [N-1:0]    done;

  modport master (
    output req, delay,
    input  grant, active_id, busy, beep, done
  );

  modport slave (
    input  req, delay,
    output grant, active_id, busy, beep, done
  );
endinterface

// File: rtl/alarm_scheduler.sv
// Round-robin shared alarm timer: grants one requester, counts its delay,
// beeps for BEEP_CYCLES, then pulses that requester's done.
module alarm_scheduler #(
  parameter int N           = 4,
  parameter int DW          = 4,
  parameter int BEEP_CYCLES = 2
) (
  input  logic            clock,
  input  logic            reset,
  alarm_scheduler_if.slave bus
);
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int BW = (BEEP_CYCLES > 1) ? $clog2(BEEP_CYCLES) : 1;
  localparam logic [BW-1:0] BEAT_LAST = BW'(BEEP_CYCLES - 1);
  localparam logic [IW-1:0] ID_LAST   = IW'(N - 1);

  typedef enum logic [1:0] {S_IDLE, S_COUNT, S_BEEP, S_DONE} state_t;

  state_t        r_state;
  logic [N-1:0]  r_grant;
  logic [N-1:0]  r_done;
  logic [IW-1:0] r_active;
  logic [IW-1:0] r_ptr;
  logic          r_busy;
  logic          r_beep;
  logic [DW-1:0] r_cnt;
  logic [BW-1:0] r_beat;

  logic          w_any;
  logic [IW-1:0] w_sel;
  logic [IW-1:0] w_next_ptr;
  logic [DW-1:0] w_sel_delay;
  logic          w_req_act;
  logic          w_cancel;

  // Offsets are scanned from farthest to nearest so the request closest to
  // the pointer (upward, wrapping) is the one left standing.
  always_comb begin
    w_any = 1'b0;
    w_sel = '0;
    for (int i = N - 1; i >= 0; i--) begin
      for (int j = 0; j < N; j++) begin
        if (r_ptr == IW'(j) && bus.req[(j + i) % N]) begin
          w_any = 1'b1;
          w_sel = IW'((j + i) % N);
        end
      end
    end
  end

  always_comb begin
    w_sel_delay = '0;
    w_req_act   = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (w_sel == IW'(i))
        w_sel_delay = bus.delay[i*DW +: DW];
      if (r_active == IW'(i))
        w_req_act = bus.req[i];
    end
  end

  assign w_next_ptr = (r_active == ID_LAST) ? '0 : r_active + IW'(1);
  assign w_cancel   = ((r_state == S_COUNT) || (r_state == S_BEEP)) && !w_req_act;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_grant  <= '0;
      r_done   <= '0;
      r_active <= '0;
      r_ptr    <= '0;
      r_busy   <= 1'b0;
      r_beep   <= 1'b0;
      r_cnt    <= '0;
      r_beat   <= '0;
    end else if (w_cancel) begin
      r_state  <= S_IDLE;
      r_grant  <= '0;
      r_active <= '0;
      r_busy   <= 1'b0;
      r_beep   <= 1'b0;
      r_cnt    <= '0;
      r_ptr    <= w_next_ptr;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= '0;
          if (w_any) begin
            r_grant  <= N'(1) << w_sel;
            r_active <= w_sel;
            r_busy   <= 1'b1;
            r_cnt    <= w_sel_delay;
            r_beat   <= '0;
            // A zero delay beeps in the very cycle the grant appears.
            if (w_sel_delay == '0) begin
              r_beep  <= 1'b1;
              r_state <= S_BEEP;
            end else begin
              r_state <= S_COUNT;
            end
          end
        end
        S_COUNT: begin
          if (r_cnt == DW'(1)) begin
            r_cnt   <= '0;
            r_beep  <= 1'b1;
            r_beat  <= '0;
            r_state <= S_BEEP;
          end else begin
            r_cnt <= r_cnt - DW'(1);
          end
        end
        S_BEEP: begin
          if (r_beat == BEAT_LAST) begin
            r_beep  <= 1'b0;
            r_done  <= r_grant;
            r_ptr   <= w_next_ptr;
            r_state <= S_DONE;
          end else begin
            r_beat <= r_beat + BW'(1);
          end
        end
        S_DONE: begin
          r_done   <= '0;
          r_grant  <= '0;
          r_active <= '0;
          r_busy   <= 1'b0;
          r_state  <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.grant     = r_grant;
  assign bus.active_id = r_active;
  assign bus.busy      = r_busy;
  assign bus.beep      = r_beep;
  assign bus.done      = r_done;
endmodule

// File: tb/tb_alarm_scheduler.sv
// Bench for alarm_scheduler: each scenario pushes the per-cycle output
// bundle it requires, and a negedge monitor pops and compares.
module tb_alarm_scheduler;
  localparam int N  = 4;
  localparam int DW = 4;
  localparam int B  = 2;

  logic clock = 1'b0;
  logic reset;
  int   cyc   = 0;
  int   n_vec = 0;
  int   n_err = 0;
  bit   mon_en = 1'b0;

  int          q_cyc[$];
  logic [11:0] q_val[$];
  string       q_tag[$];

  alarm_scheduler_if #(.N(N), .DW(DW)) bus();

  alarm_scheduler #(.N(N), .DW(DW), .BEEP_CYCLES(B)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [11:0] pk(input logic [3:0] g, input logic [1:0] a,
                                     input logic bz, input logic bp, input logic [3:0] d);
    return {g, a, bz, bp, d};
  endfunction

  task automatic expect_at(input int c, input string tag, input logic [11:0] v);
    q_cyc.push_back(c);
    q_val.push_back(v);
    q_tag.push_back(tag);
  endtask

  // Full service of requester id with delay d, grant first visible at cycle t.
  task automatic push_svc(input int id, input int d, input int t, input string tag);
    logic [3:0] oh;
    logic       bp;
    oh = 4'b0001 << id;
    for (int x = t; x <= t + d + B; x++) begin
      bp = (x >= t + d) && (x < t + d + B);
      expect_at(x, tag, pk(oh, 2'(id), 1'b1, bp, (x == t + d + B) ? oh : 4'b0000));
    end
    expect_at(t + d + B + 1, {tag, "_idle"}, 12'h000);
  endtask

  task automatic wait_to(input int c);
    while (cyc < c) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic single(input int id, input int d, input string tag);
    int t;
    bus.delay[id*DW +: DW] = DW'(d);
    bus.req       = '0;
    bus.req[id]   = 1'b1;
    t = cyc + 1;
    push_svc(id, d, t, tag);
    wait_to(t + d + B);
    bus.req = '0;
    wait_to(t + d + B + 2);
  endtask

  always @(negedge clock) begin
    if (mon_en) begin
      chk("grant_onehot", 32'($countones(bus.grant) <= 1), 32'd1);
      chk("done_onehot_nobeep",
          32'(($countones(bus.done) <= 1) && !((|bus.done) && bus.beep)), 32'd1);
    end
    while (q_cyc.size() > 0 && q_cyc[0] <= cyc) begin
      chk($sformatf("%s@%0d", q_tag[0], q_cyc[0]),
          {20'b0, bus.grant, bus.active_id, bus.busy, bus.beep, bus.done},
          {20'b0, q_val[0]});
      void'(q_cyc.pop_front());
      void'(q_val.pop_front());
      void'(q_tag.pop_front());
    end
  end

  initial begin
    int t;
    reset     = 1'b1;
    bus.req   = '0;
    bus.delay = '0;
    repeat (3) @(posedge clock);
    #1;
    reset  = 1'b0;
    mon_en = 1'b1;
    expect_at(cyc, "rst", 12'h000);
    expect_at(cyc + 1, "rst_idle", 12'h000);
    wait_to(cyc + 2);

    single(0, 3, "t1");
    single(0, 0, "t2");

    // Two requesters held continuously alternate, one idle cycle apart.
    bus.delay[7:4]   = 4'd2;
    bus.delay[15:12] = 4'd5;
    bus.req = 4'b1010;
    t = cyc + 1;
    push_svc(1, 2, t, "t3a");
    push_svc(3, 5, t + 6, "t3b");
    push_svc(1, 2, t + 15, "t3c");
    wait_to(t + 15 + 2 + B);
    bus.req = '0;
    wait_to(t + 15 + 2 + B + 2);

    // Cancel mid-count: no beep, no done, pointer still moves past 2.
    bus.delay[11:8] = 4'd9;
    bus.req = 4'b0100;
    t = cyc + 1;
    for (int x = t; x <= t + 4; x++) expect_at(x, "t4cnt", pk(4'b0100, 2'd2, 1'b1, 1'b0, 4'b0000));
    for (int x = t + 5; x <= t + 12; x++) expect_at(x, "t4cancel", 12'h000);
    wait_to(t + 4);
    bus.req = '0;
    wait_to(t + 13);
    bus.delay[3:0]   = 4'd1;
    bus.delay[15:12] = 4'd1;
    bus.req = 4'b1001;
    t = cyc + 1;
    push_svc(3, 1, t, "t4next");
    wait_to(t + 1 + B);
    bus.req = '0;
    wait_to(t + 1 + B + 2);

    // Move the pointer to 2, then reset during requester 2's first beep.
    single(1, 1, "t5pre");
    bus.delay[11:8] = 4'd2;
    bus.req = 4'b0100;
    t = cyc + 1;
    expect_at(t, "t5cnt", pk(4'b0100, 2'd2, 1'b1, 1'b0, 4'b0000));
    expect_at(t + 1, "t5cnt", pk(4'b0100, 2'd2, 1'b1, 1'b0, 4'b0000));
    expect_at(t + 2, "t5beep", pk(4'b0100, 2'd2, 1'b1, 1'b1, 4'b0000));
    expect_at(t + 3, "t5rst", 12'h000);
    wait_to(t + 2);
    reset     = 1'b1;
    bus.delay = 16'h1111;
    bus.req   = 4'b1111;
    wait_to(t + 3);
    reset = 1'b0;
    push_svc(0, 1, t + 4, "t5post");
    wait_to(t + 4 + 1 + B);
    bus.req = '0;
    wait_to(t + 4 + 1 + B + 2);

    // Delay change after grant is ignored; re-request picks up the new value.
    bus.delay[7:4] = 4'd4;
    bus.req = 4'b0010;
    t = cyc + 1;
    push_svc(1, 4, t, "t6a");
    push_svc(1, 15, t + 8, "t6b");
    wait_to(t + 2);
    bus.delay[7:4] = 4'd15;
    wait_to(t + 8 + 15 + B);
    bus.req = '0;
    wait_to(t + 8 + 15 + B + 2);

    chk("sb_empty", 32'(q_cyc.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
